// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: incrementing bursts with cti tagging,
// write-data flow control and ack-timeout abort.
module wb_burst_master #(
  parameter int APP_AW  = 26,
  parameter int DW      = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err_timeout,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [APP_AW-1:0] wb_addr,
  output logic [DW-1:0]     wb_dati,
  output logic [DW/8-1:0]   wb_sel,
  output logic [2:0]        wb_cti,
  input  logic [DW-1:0]     wb_dato,
  input  logic              wb_ack
);

  localparam int SW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;
  localparam logic [APP_AW-1:0] STEP = APP_AW'(SW);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [0:0]        r_state;
  logic              r_we;
  logic              r_cyc;
  logic              r_stb;
  logic              r_burst;
  logic              r_done;
  logic              r_err;
  logic              r_rd_valid;
  logic [APP_AW-1:0] r_addr;
  logic [DW-1:0]     r_dati;
  logic [DW-1:0]     r_rd_data;
  logic [SW-1:0]     r_sel;
  logic [2:0]        r_cti;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W:0]    r_lcnt;
  logic [TW-1:0]     r_tmo;

  logic w_bus;
  logic w_start;
  logic w_ack;
  logic w_last;
  logic w_tmo;
  logic w_wr_rdy;
  logic w_wr;

  assign w_bus   = (r_state == S_BUS);
  assign w_start = ~w_bus & cmd_valid;
  assign w_ack   = w_bus & r_stb & wb_ack;
  assign w_last  = w_ack & (r_cnt == '0);
  assign w_tmo   = w_bus & r_stb & ~wb_ack
                 & (r_tmo == TMO_LAST);
  // r_lcnt stops the beat register loading past the burst end
  assign w_wr_rdy = w_bus & r_we & (r_lcnt != '0)
                  & (~r_stb | wb_ack);
  assign w_wr     = w_wr_rdy & wr_valid;

  assign cmd_ready   = ~w_bus;
  assign wr_ready    = w_wr_rdy;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign wb_cyc      = r_cyc;
  assign wb_stb      = r_stb;
  assign wb_we       = r_we;
  assign wb_addr     = r_addr;
  assign wb_dati     = r_dati;
  assign wb_sel      = r_sel;
  assign wb_cti      = r_cti;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_burst    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr     <= '0;
      r_dati     <= '0;
      r_rd_data  <= '0;
      r_sel      <= '0;
      r_cti      <= 3'b000;
      r_cnt      <= '0;
      r_lcnt     <= '0;
      r_tmo      <= '0;
    end else begin
      r_done     <= w_last;
      r_err      <= w_tmo;
      r_rd_valid <= w_ack & ~r_we;
      if (w_ack & ~r_we)
        r_rd_data <= wb_dato;
      if (w_ack)
        r_addr <= r_addr + STEP;
      if (w_start) begin
        r_state <= S_BUS;
        r_cyc   <= 1'b1;
        r_we    <= cmd_we;
        r_addr  <= cmd_addr;
        r_sel   <= cmd_sel;
        r_cnt   <= cmd_len;
        r_burst <= (cmd_len != '0);
        r_cti   <= (cmd_len != '0) ? 3'b010 : 3'b000;
        r_stb   <= ~cmd_we;
        r_lcnt  <= cmd_we ? ({1'b0, cmd_len} + 1'b1) : '0;
        r_tmo   <= '0;
      end else if (w_bus) begin
        if (w_last | w_tmo) begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_cti   <= 3'b000;
          r_lcnt  <= '0;
          r_tmo   <= '0;
        end else begin
          if (w_ack) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_burst && r_cnt == LEN_W'(1))
              r_cti <= 3'b111;
          end
          if (r_we)
            r_stb <= w_wr | (r_stb & ~wb_ack);
          if (w_wr) begin
            r_dati <= wr_data;
            r_lcnt <= r_lcnt - 1'b1;
          end
          if (~r_stb | wb_ack)
            r_tmo <= '0;
          else
            r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: table of bursts plus
// hand-written corner sequences, with a beat scoreboard.
module tb_wb_burst_master;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int TMO = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [3:0]    cmd_sel = '0;
  logic [DW-1:0] wr_data;
  logic          wr_valid = 1'b1;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err_timeout;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_dati;
  logic [3:0]    wb_sel;
  logic [2:0]    wb_cti;
  logic [DW-1:0] wb_dato;
  logic          wb_ack;

  always #5 wb_clk = ~wb_clk;

  wb_burst_master #(
    .APP_AW(AW), .DW(DW), .LEN_W(LW), .TIMEOUT(TMO)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done),
    .err_timeout(err_timeout), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_dati(wb_dati), .wb_sel(wb_sel), .wb_cti(wb_cti),
    .wb_dato(wb_dato), .wb_ack(wb_ack)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [2:0]    cti;
    logic [3:0]    sel;
  } beat_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [3:0]    sel;
    int            wt;
    int            exp_beats;
    logic [2:0]    exp_cti;
  } vec_t;

  beat_t       bq[$];
  logic [31:0] rq[$];
  beat_t       mb;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;
  int n_ack = 0;
  int n_wr = 0;
  int n_wexp = 0;
  int cyc_n = 0;
  int t_ack = 0;
  logic [2:0] last_cti = 3'b000;

  int s_wait = 0;
  int s_cnt = 0;
  bit s_never = 1'b0;
  bit s_fixed = 1'b0;

  assign wb_ack = wb_cyc & wb_stb & ~s_never & (s_cnt >= s_wait);
  assign wb_dato = s_fixed ? 32'hDEADBEEF : {6'h2A, wb_addr};
  assign wr_data = 32'hC0DE0000 + 32'(n_wr);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge wb_clk) begin
    cyc_n <= cyc_n + 1;
    if (wr_valid & wr_ready) n_wr <= n_wr + 1;
    if (wb_cyc & wb_stb & ~wb_ack) s_cnt <= s_cnt + 1;
    else s_cnt <= 0;
  end

  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      if (wb_cyc & wb_stb & wb_ack) begin
        n_ack++;
        t_ack = cyc_n;
        last_cti = wb_cti;
        if (bq.size() == 0) begin
          chk("unexpected_ack", 64'(bq.size()), 1);
        end else begin
          mb = bq.pop_front();
          chk("beat_we", wb_we, mb.we);
          chk("beat_addr", wb_addr, mb.addr);
          chk("beat_cti", wb_cti, mb.cti);
          chk("beat_sel", wb_sel, mb.sel);
          if (mb.we) chk("beat_wdata", wb_dati, mb.data);
          else rq.push_back(mb.data);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) chk("unexpected_rd", 64'(rq.size()), 1);
        else chk("rd_data", rd_data, rq.pop_front());
      end
      if (done) begin
        n_done++;
        chk("done_latency", 64'(cyc_n - t_ack), 1);
      end
      if (err_timeout) n_err++;
    end
  end

  task automatic expect_cmd(input logic we, input logic [AW-1:0] a,
                            input logic [LW-1:0] l,
                            input logic [3:0] s, input bit fixed);
    beat_t b;
    for (int i = 0; i <= int'(l); i++) begin
      b.we   = we;
      b.addr = a + AW'(4 * i);
      b.sel  = s;
      b.cti  = (l == 0) ? 3'b000 : ((i == int'(l)) ? 3'b111 : 3'b010);
      if (we) begin
        b.data = 32'hC0DE0000 + 32'(n_wexp);
        n_wexp++;
      end else begin
        b.data = fixed ? 32'hDEADBEEF : {6'h2A, b.addr};
      end
      bq.push_back(b);
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a,
                       input logic [LW-1:0] l, input logic [3:0] s);
    @(negedge wb_clk);
    cmd_we = we;
    cmd_addr = a;
    cmd_len = l;
    cmd_sel = s;
    cmd_valid = 1'b1;
    for (int k = 0; k < 300 && !cmd_ready; k++) @(negedge wb_clk);
    chk("cmd_accept", cmd_ready, 1);
    @(posedge wb_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    for (int k = 0; k < 400; k++) begin
      if (n_done + n_err > d0 + e0) break;
      @(posedge wb_clk);
      #1;
    end
    chk("burst_end", 64'(n_done + n_err), 64'(d0 + e0 + 1));
  endtask

  vec_t tbl[6];
  int d0, e0, a0, w0, sc;

  initial begin
    tbl[0] = '{1'b0, 26'h0000200, 4'd3,  4'hF, 1, 4,  3'b111};
    tbl[1] = '{1'b1, 26'h3FFFFF8, 4'd3,  4'hF, 0, 4,  3'b111};
    tbl[2] = '{1'b1, 26'h0000040, 4'd0,  4'h3, 1, 1,  3'b000};
    tbl[3] = '{1'b0, 26'h1234560, 4'd15, 4'hC, 0, 16, 3'b111};
    tbl[4] = '{1'b1, 26'h0000800, 4'd1,  4'h1, 3, 2,  3'b111};
    tbl[5] = '{1'b0, 26'h3FFFFFC, 4'd1,  4'hF, 0, 2,  3'b111};

    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_cti, wb_sel}, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_dati", wb_dati, 0);
    chk("rst_rd", {rd_data, rd_valid}, 0);
    chk("rst_pulses", {done, err_timeout, wr_ready}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    wb_rst = 1'b0;

    // single read with a two-cycle slave
    s_fixed = 1'b1;
    s_wait = 2;
    d0 = n_done; e0 = n_err; a0 = n_ack;
    expect_cmd(1'b0, 26'h0000100, 4'd0, 4'hF, 1'b1);
    issue(1'b0, 26'h0000100, 4'd0, 4'hF);
    wait_end(d0, e0);
    chk("single_acks", 64'(n_ack - a0), 1);
    chk("single_cti", last_cti, 3'b000);
    chk("single_err", 64'(n_err), 64'(e0));
    s_fixed = 1'b0;

    for (int i = 0; i < 6; i++) begin
      s_wait = tbl[i].wt;
      d0 = n_done; e0 = n_err; a0 = n_ack; w0 = n_wr;
      expect_cmd(tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].sel, 1'b0);
      issue(tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].sel);
      wait_end(d0, e0);
      chk("vec_beats", 64'(n_ack - a0), 64'(tbl[i].exp_beats));
      chk("vec_last_cti", last_cti, tbl[i].exp_cti);
      chk("vec_err", 64'(n_err), 64'(e0));
      if (tbl[i].we)
        chk("vec_wr_beats", 64'(n_wr - w0), 64'(tbl[i].exp_beats));
      chk("vec_queues", 64'(bq.size() + rq.size()), 0);
    end

    // write data starvation mid-burst
    s_wait = 0;
    d0 = n_done; e0 = n_err; a0 = n_ack; w0 = n_wr;
    expect_cmd(1'b1, 26'h0000700, 4'd3, 4'hF, 1'b0);
    issue(1'b1, 26'h0000700, 4'd3, 4'hF);
    for (int k = 0; k < 50 && n_wr < w0 + 2; k++) begin
      @(posedge wb_clk);
      #1;
    end
    wr_valid = 1'b0;
    repeat (5) @(negedge wb_clk);
    chk("starve_stb", wb_stb, 0);
    chk("starve_cyc", wb_cyc, 1);
    @(posedge wb_clk);
    #1 wr_valid = 1'b1;
    wait_end(d0, e0);
    chk("starve_acks", 64'(n_ack - a0), 4);
    chk("starve_err", 64'(n_err), 64'(e0));

    // timeout: slave never acks
    s_never = 1'b1;
    d0 = n_done; e0 = n_err;
    issue(1'b0, 26'h0000900, 4'd1, 4'hF);
    sc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge wb_clk);
      if (err_timeout) break;
      if (wb_stb) sc++;
    end
    chk("tmo_err_pulse", err_timeout, 1);
    chk("tmo_stb_cycles", 64'(sc), TMO);
    chk("tmo_bus_off", {wb_cyc, wb_stb}, 0);
    chk("tmo_cmd_ready", cmd_ready, 1);
    repeat (3) @(posedge wb_clk);
    #1;
    chk("tmo_no_done", 64'(n_done), 64'(d0));
    chk("tmo_err_once", 64'(n_err), 64'(e0 + 1));
    s_never = 1'b0;

    // reset after two of eight read acks
    s_wait = 1;
    a0 = n_ack;
    expect_cmd(1'b0, 26'h0000500, 4'd7, 4'hF, 1'b0);
    issue(1'b0, 26'h0000500, 4'd7, 4'hF);
    for (int k = 0; k < 100 && n_ack < a0 + 2; k++) begin
      @(posedge wb_clk);
      #1;
    end
    d0 = n_done; e0 = n_err;
    wb_rst = 1'b1;
    @(posedge wb_clk);
    #1;
    chk("mid_rst_bus", {wb_cyc, wb_stb, wb_we, wb_cti, wb_sel}, 0);
    chk("mid_rst_addr", wb_addr, 0);
    chk("mid_rst_pulses", {rd_valid, done, err_timeout, wr_ready}, 0);
    bq.delete();
    rq.delete();
    wb_rst = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    chk("mid_rst_no_pulse", 64'(n_done + n_err), 64'(d0 + e0));
    d0 = n_done; e0 = n_err;
    expect_cmd(1'b0, 26'h0000600, 4'd3, 4'hF, 1'b0);
    issue(1'b0, 26'h0000600, 4'd3, 4'hF);
    wait_end(d0, e0);
    chk("post_rst_done", 64'(n_done), 64'(d0 + 1));

    // back-to-back commands
    s_wait = 0;
    expect_cmd(1'b0, 26'h0000300, 4'd2, 4'hF, 1'b0);
    expect_cmd(1'b1, 26'h0000400, 4'd1, 4'h5, 1'b0);
    issue(1'b0, 26'h0000300, 4'd2, 4'hF);
    @(negedge wb_clk);
    cmd_we = 1'b1;
    cmd_addr = 26'h0000400;
    cmd_len = 4'd1;
    cmd_sel = 4'h5;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge wb_clk);
    chk("b2b_done_pulse", done, 1);
    @(posedge wb_clk);
    #1 cmd_valid = 1'b0;
    d0 = n_done; e0 = n_err;
    @(negedge wb_clk);
    chk("b2b_cyc", wb_cyc, 1);
    wait_end(d0, e0);
    chk("b2b_queues", 64'(bq.size() + rq.size()), 0);

    repeat (2) @(posedge wb_clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
